// File: rtl/pll_pkg.sv
// Shared PLL definitions: phase-detector state encoding and TDC range helper.
// Used by tdc_pfd and by the loop filter / NCO blocks.
package pll_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REF_LEAD = 2'd1,
        CMP_LEAD = 2'd2
    } pfd_state_e;

    // Largest magnitude representable by a signed TDC word of the given width.
    function automatic int tdc_max(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

endpackage

// File: rtl/tdc_pfd_edge_sync.sv
// Edge synchroniser: SYNC_STAGES-deep metastability chain followed by a
// history flop; rise is high for one clk per synchronised rising edge.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic ext_rst_n,
    input  logic sig,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;

    // Synchroniser chain and previous-value flop.
    always_ff @(posedge clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            sync_r <= '0;
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], sig};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign rise = sync_r[SYNC_STAGES-1] & ~prev_r;

endmodule

// File: rtl/tdc_pfd.sv
// Time-to-digital phase/frequency detector with slip and timeout detection.
// Optional lock detector is compiled in when LOCK_DETECT_EN is defined.
module tdc_pfd
    import pll_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 4096,
    parameter int LOCK_TOL    = 4,
    parameter int LOCK_CNT    = 8
) (
    input  logic                    clk,
    input  logic                    ext_rst_n,
    input  logic                    ref_sig,
    input  logic                    cmp_sig,
    output logic signed [WIDTH-1:0] tdc,
    output logic                    valid,
    output logic                    slip,
    output logic                    timeout,
    output logic                    lock
);

    localparam int            CW      = WIDTH - 1;
    localparam logic [CW-1:0] MAG_MAX = CW'(tdc_max(WIDTH));
    localparam logic [CW-1:0] MAG_TMO = CW'(TIMEOUT);
    localparam logic [CW-1:0] MAG_ONE = CW'(1);

    logic                    ref_rise_s;
    logic                    cmp_rise_s;
    logic                    lead_rise_s;
    logic                    lag_rise_s;
    logic                    close_s;
    logic                    slip_s;
    logic                    tmo_s;
    logic [CW-1:0]           mag_s;
    logic signed [WIDTH-1:0] result_s;

    pfd_state_e              state_r;
    logic [CW-1:0]           counter_r;
    logic signed [WIDTH-1:0] tdc_r;
    logic                    valid_r;
    logic                    slip_r;
    logic                    timeout_r;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
        .clk       (clk),
        .ext_rst_n (ext_rst_n),
        .sig       (ref_sig),
        .rise      (ref_rise_s)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cmp_sync (
        .clk       (clk),
        .ext_rst_n (ext_rst_n),
        .sig       (cmp_sig),
        .rise      (cmp_rise_s)
    );

    // Event decode: closing edge beats slip, slip beats timeout.
    always_comb begin
        lead_rise_s = 1'b0;
        lag_rise_s  = 1'b0;
        close_s     = 1'b0;
        slip_s      = 1'b0;
        tmo_s       = 1'b0;
        mag_s       = '0;
        case (state_r)
            IDLE: begin
                if (ref_rise_s && cmp_rise_s) begin
                    close_s = 1'b1;
                end else begin
                    close_s = 1'b0;
                end
            end
            REF_LEAD, CMP_LEAD: begin
                lead_rise_s = (state_r == REF_LEAD) ? ref_rise_s : cmp_rise_s;
                lag_rise_s  = (state_r == REF_LEAD) ? cmp_rise_s : ref_rise_s;
                if (lag_rise_s) begin
                    close_s = 1'b1;
                    mag_s   = counter_r;
                end else if (lead_rise_s) begin
                    close_s = 1'b1;
                    slip_s  = 1'b1;
                    mag_s   = MAG_MAX;
                end else if (counter_r == MAG_TMO) begin
                    tmo_s = 1'b1;
                end else begin
                    tmo_s = 1'b0;
                end
            end
            default: begin
                close_s = 1'b0;
            end
        endcase
        if (state_r == CMP_LEAD) begin
            result_s = -$signed({1'b0, mag_s});
        end else begin
            result_s = $signed({1'b0, mag_s});
        end
    end

    // Detector FSM with lead counter and registered result strobes.
    always_ff @(posedge clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            state_r   <= IDLE;
            counter_r <= '0;
            tdc_r     <= '0;
            valid_r   <= 1'b0;
            slip_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            valid_r   <= close_s;
            slip_r    <= slip_s;
            timeout_r <= tmo_s;
            if (close_s) begin
                tdc_r <= result_s;
            end else begin
                tdc_r <= tdc_r;
            end
            case (state_r)
                IDLE: begin
                    if (ref_rise_s && cmp_rise_s) begin
                        state_r   <= IDLE;
                        counter_r <= '0;
                    end else if (ref_rise_s) begin
                        state_r   <= REF_LEAD;
                        counter_r <= MAG_ONE;
                    end else if (cmp_rise_s) begin
                        state_r   <= CMP_LEAD;
                        counter_r <= MAG_ONE;
                    end else begin
                        state_r   <= IDLE;
                        counter_r <= counter_r;
                    end
                end
                REF_LEAD, CMP_LEAD: begin
                    if (lag_rise_s && lead_rise_s) begin
                        state_r   <= state_r;
                        counter_r <= MAG_ONE;
                    end else if (lag_rise_s) begin
                        state_r   <= IDLE;
                        counter_r <= '0;
                    end else if (lead_rise_s) begin
                        state_r   <= state_r;
                        counter_r <= MAG_ONE;
                    end else if (tmo_s) begin
                        state_r   <= IDLE;
                        counter_r <= '0;
                    end else if (counter_r != MAG_MAX) begin
                        state_r   <= state_r;
                        counter_r <= counter_r + MAG_ONE;
                    end else begin
                        state_r   <= state_r;
                        counter_r <= counter_r;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    counter_r <= '0;
                end
            endcase
        end
    end

    assign tdc     = tdc_r;
    assign valid   = valid_r;
    assign slip    = slip_r;
    assign timeout = timeout_r;

`ifdef LOCK_DETECT_EN
    localparam int             LCW       = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0]  MAG_TOL   = CW'(LOCK_TOL);
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CNT - 1);
    localparam logic [LCW-1:0] LOCK_FULL = LCW'(LOCK_CNT);

    logic [LCW-1:0] lock_ctr_r;
    logic           lock_r;

    // Lock qualifier, updated on the same edge as the result it judges.
    always_ff @(posedge clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            lock_ctr_r <= '0;
            lock_r     <= 1'b0;
        end else if (slip_s || tmo_s || (close_s && (mag_s > MAG_TOL))) begin
            lock_ctr_r <= '0;
            lock_r     <= 1'b0;
        end else if (close_s) begin
            if (lock_ctr_r >= LOCK_LAST) begin
                lock_ctr_r <= LOCK_FULL;
                lock_r     <= 1'b1;
            end else begin
                lock_ctr_r <= lock_ctr_r + LCW'(1);
                lock_r     <= lock_r;
            end
        end else begin
            lock_ctr_r <= lock_ctr_r;
            lock_r     <= lock_r;
        end
    end

    assign lock = lock_r;
`else
    assign lock = 1'b0;
`endif

endmodule

// File: tb/tb_tdc_pfd.sv
// Directed bench for tdc_pfd (WIDTH=16, SYNC_STAGES=2, TIMEOUT=4096).
// Lock sequence is exercised when LOCK_DETECT_EN is defined.
module tb_tdc_pfd;

    logic        clk = 1'b0;
    logic        ext_rst_n;
    logic        ref_sig;
    logic        cmp_sig;
    logic [15:0] tdc;
    logic        valid;
    logic        slip;
    logic        timeout;
    logic        lock;

    int n_checks = 0;
    int n_pass   = 0;
    int n_valid  = 0;

    always #5 clk = ~clk;

    tdc_pfd #(
        .WIDTH       (16),
        .SYNC_STAGES (2),
        .TIMEOUT     (4096),
        .LOCK_TOL    (4),
        .LOCK_CNT    (8)
    ) dut (
        .clk       (clk),
        .ext_rst_n (ext_rst_n),
        .ref_sig   (ref_sig),
        .cmp_sig   (cmp_sig),
        .tdc       (tdc),
        .valid     (valid),
        .slip      (slip),
        .timeout   (timeout),
        .lock      (lock)
    );

    always @(negedge clk) begin
        if (valid) n_valid <= n_valid + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk);
            if (valid) found = 1'b1;
        end
    endtask

    // gap==0 drives both edges together; otherwise the lagging edge follows gap clks later.
    task automatic measure(input string tag, input bit ref_first, input int gap,
                           input logic [31:0] exp_tdc, input logic exp_lock);
        bit found;
        int v0;
        v0 = n_valid;
        tick(1);
        if (gap == 0) begin
            ref_sig = 1'b1;
            cmp_sig = 1'b1;
        end else begin
            if (ref_first) ref_sig = 1'b1; else cmp_sig = 1'b1;
            tick(gap);
            if (ref_first) cmp_sig = 1'b1; else ref_sig = 1'b1;
        end
        wait_valid(20, found);
        check({tag, "_valid"}, 32'(found), 32'd1);
        check({tag, "_tdc"}, 32'(tdc), exp_tdc);
        check({tag, "_slip"}, 32'(slip), 32'd0);
        check({tag, "_lock"}, 32'(lock), 32'(exp_lock));
        tick(1);
        ref_sig = 1'b0;
        cmp_sig = 1'b0;
        tick(8);
        check({tag, "_nvalid"}, 32'(n_valid - v0), 32'd1);
    endtask

    initial begin
        bit found;
        int cyc;
        int v0;
        ext_rst_n = 1'b0;
        ref_sig   = 1'b0;
        cmp_sig   = 1'b0;
        tick(3);
        check("rst_tdc", 32'(tdc), 32'd0);
        check("rst_strobes", {29'd0, valid, slip, timeout}, 32'd0);
        check("rst_lock", 32'(lock), 32'd0);
        ext_rst_n = 1'b1;
        tick(5);

        measure("ref_lead10", 1'b1, 10, 32'h0000_000A, 1'b0);
        measure("cmp_lead7", 1'b0, 7, 32'h0000_FFF9, 1'b0);
        measure("coincident", 1'b1, 0, 32'h0000_0000, 1'b0);
        measure("after_coinc", 1'b1, 4, 32'h0000_0004, 1'b0);

        // Reference slip followed by timeout abort.
        v0 = n_valid;
        tick(1);
        ref_sig = 1'b1;
        tick(3);
        ref_sig = 1'b0;
        tick(47);
        ref_sig = 1'b1;
        wait_valid(20, found);
        check("slip_valid", 32'(found), 32'd1);
        check("slip_flag", 32'(slip), 32'd1);
        check("slip_tdc", 32'(tdc), 32'h0000_7FFF);
        check("slip_tmo", 32'(timeout), 32'd0);
        ref_sig = 1'b0;
        cyc   = 0;
        found = 1'b0;
        for (int i = 0; i < 5000 && !found; i++) begin
            @(negedge clk);
            cyc++;
            if (timeout) found = 1'b1;
        end
        check("tmo_seen", 32'(found), 32'd1);
        check("tmo_delay", 32'(cyc), 32'd4096);
        check("tmo_tdc_hold", 32'(tdc), 32'h0000_7FFF);
        check("tmo_novalid", 32'(valid), 32'd0);
        check("tmo_nvalid", 32'(n_valid - v0), 32'd1);
        tick(5);
        measure("post_tmo", 1'b1, 6, 32'h0000_0006, 1'b0);

        // Reset in the middle of a reference-lead measurement.
        measure("pre_rst", 1'b1, 12, 32'h0000_000C, 1'b0);
        tick(1);
        ref_sig = 1'b1;
        tick(21);
        ext_rst_n = 1'b0;
        #1;
        check("arst_tdc", 32'(tdc), 32'd0);
        check("arst_strobes", {29'd0, valid, slip, timeout}, 32'd0);
        check("arst_lock", 32'(lock), 32'd0);
        ref_sig = 1'b0;
        tick(3);
        ext_rst_n = 1'b1;
        tick(3);
        measure("post_rst", 1'b0, 3, 32'h0000_FFFD, 1'b0);

        // Feedback slip, then closed by the reference.
        tick(1);
        cmp_sig = 1'b1;
        tick(3);
        cmp_sig = 1'b0;
        tick(20);
        cmp_sig = 1'b1;
        wait_valid(20, found);
        check("cslip_valid", 32'(found), 32'd1);
        check("cslip_flag", 32'(slip), 32'd1);
        check("cslip_tdc", 32'(tdc), 32'h0000_8001);
        tick(4);
        ref_sig = 1'b1;
        wait_valid(20, found);
        check("cslip_close", 32'(found), 32'd1);
        check("cslip_close_tdc", 32'(tdc), 32'h0000_FFF9);
        check("cslip_close_slip", 32'(slip), 32'd0);
        tick(1);
        ref_sig = 1'b0;
        cmp_sig = 1'b0;
        tick(8);

`ifdef LOCK_DETECT_EN
        for (int i = 1; i <= 8; i++) begin
            measure("lock_in", 1'b1, 3, 32'h0000_0003, (i == 8));
        end
        measure("lock_out", 1'b1, 5, 32'h0000_0005, 1'b0);
`else
        measure("nolock", 1'b1, 3, 32'h0000_0003, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
